// File: rtl/multicycle_controller_if.sv
// Control bundle between the multi-cycle controller and the RV32I datapath:
// instruction fields and ALU flags in, mux selects and write strobes out.
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] func3;
    logic       zero;
    logic       lt;
    logic       mem_ready;
    logic [1:0] alu_op;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] imm_src;
    logic       adr_src;
    logic       ir_write;
    logic       pc_update;
    logic       reg_write;
    logic       mem_write;
    logic       instr_done;
    logic       illegal;

    modport master (
        input  op, func3, zero, lt, mem_ready,
        output alu_op, alu_src_a, alu_src_b, result_src, imm_src, adr_src,
               ir_write, pc_update, reg_write, mem_write, instr_done, illegal
    );

    modport slave (
        output op, func3, zero, lt, mem_ready,
        input  alu_op, alu_src_a, alu_src_b, result_src, imm_src, adr_src,
               ir_write, pc_update, reg_write, mem_write, instr_done, illegal
    );
endinterface

// File: rtl/multicycle_controller.sv
// Main sequencing FSM of the multi-cycle RV32I core: fetch, decode, execute,
// memory and writeback, stalling on the shared memory's mem_ready.
module multicycle_controller (
    input  logic                       clk,
    input  logic                       reset,
    multicycle_controller_if.master    ctrl
);
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        JAL      = 4'd9,
        BRANCH   = 4'd10
    } state_t;

    state_t     state_r;
    state_t     next_state_s;
    logic [1:0] alu_op_s;
    logic [1:0] alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [1:0] result_src_s;
    logic       adr_src_s;
    logic       ir_write_s;
    logic       pc_update_s;
    logic       reg_write_s;
    logic       mem_write_s;
    logic       instr_done_s;
    logic       illegal_s;

    function automatic logic [1:0] imm_sel(input logic [6:0] op_f);
        case (op_f)
            OP_LW, OP_I: imm_sel = 2'b00;
            OP_SW:       imm_sel = 2'b01;
            OP_BR:       imm_sel = 2'b10;
            OP_JAL:      imm_sel = 2'b11;
            default:     imm_sel = 2'b00;
        endcase
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3, input logic z, input logic l);
        case (f3)
            3'b000:  branch_taken = z;
            3'b001:  branch_taken = ~z;
            3'b100:  branch_taken = l;
            default: branch_taken = 1'b0;
        endcase
    endfunction

    // State register; reset aborts whatever instruction is in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Per-state output decode and next-state selection.
    always_comb begin
        next_state_s = FETCH;
        alu_op_s     = 2'b00;
        alu_src_a_s  = 2'b00;
        alu_src_b_s  = 2'b00;
        result_src_s = 2'b00;
        adr_src_s    = 1'b0;
        ir_write_s   = 1'b0;
        pc_update_s  = 1'b0;
        reg_write_s  = 1'b0;
        mem_write_s  = 1'b0;
        instr_done_s = 1'b0;
        illegal_s    = 1'b0;
        case (state_r)
            FETCH: begin
                alu_src_b_s  = 2'b10;
                result_src_s = 2'b10;
                ir_write_s   = ctrl.mem_ready;
                pc_update_s  = ctrl.mem_ready;
                next_state_s = ctrl.mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b01;
                case (ctrl.op)
                    OP_LW, OP_SW: next_state_s = MEMADR;
                    OP_R:         next_state_s = EXECR;
                    OP_I:         next_state_s = EXECI;
                    OP_BR:        next_state_s = BRANCH;
                    OP_JAL:       next_state_s = JAL;
                    default: begin
                        illegal_s    = 1'b1;
                        next_state_s = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a_s  = 2'b10;
                alu_src_b_s  = 2'b01;
                next_state_s = (ctrl.op == OP_SW) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                adr_src_s    = 1'b1;
                next_state_s = ctrl.mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                result_src_s = 2'b01;
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
                next_state_s = FETCH;
            end
            MEMWRITE: begin
                // Write request stays up for the whole wait; done only on completion.
                adr_src_s    = 1'b1;
                mem_write_s  = 1'b1;
                instr_done_s = ctrl.mem_ready;
                next_state_s = ctrl.mem_ready ? FETCH : MEMWRITE;
            end
            EXECR: begin
                alu_src_a_s  = 2'b10;
                alu_op_s     = 2'b10;
                next_state_s = ALUWB;
            end
            EXECI: begin
                alu_src_a_s  = 2'b10;
                alu_src_b_s  = 2'b01;
                alu_op_s     = 2'b10;
                next_state_s = ALUWB;
            end
            ALUWB: begin
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
                next_state_s = FETCH;
            end
            JAL: begin
                alu_src_a_s  = 2'b01;
                alu_src_b_s  = 2'b10;
                pc_update_s  = 1'b1;
                next_state_s = ALUWB;
            end
            BRANCH: begin
                alu_src_a_s  = 2'b10;
                alu_op_s     = 2'b01;
                instr_done_s = 1'b1;
                pc_update_s  = branch_taken(ctrl.func3, ctrl.zero, ctrl.lt);
                next_state_s = FETCH;
            end
            default: begin
                next_state_s = FETCH;
            end
        endcase
    end

    assign ctrl.alu_op     = alu_op_s;
    assign ctrl.alu_src_a  = alu_src_a_s;
    assign ctrl.alu_src_b  = alu_src_b_s;
    assign ctrl.result_src = result_src_s;
    assign ctrl.adr_src    = adr_src_s;
    assign ctrl.imm_src    = imm_sel(ctrl.op);
    // Strobes are suppressed in the reset cycle so an aborted access never writes.
    assign ctrl.ir_write   = ir_write_s   & ~reset;
    assign ctrl.pc_update  = pc_update_s  & ~reset;
    assign ctrl.reg_write  = reg_write_s  & ~reset;
    assign ctrl.mem_write  = mem_write_s  & ~reset;
    assign ctrl.instr_done = instr_done_s & ~reset;
    assign ctrl.illegal    = illegal_s    & ~reset;
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: expected output vectors are queued
// as each cycle is driven and compared at the following falling edge.
module tb_multicycle_controller;
    logic clk = 1'b0;
    logic reset;
    multicycle_controller_if bus();

    multicycle_controller dut (
        .clk  (clk),
        .reset(reset),
        .ctrl (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [16:0] exp;
        logic [16:0] mask;
    } sb_t;

    sb_t  sb_q[$];
    int   checks = 0;
    int   errors = 0;
    logic [16:0] mask_v = 17'h1FFFF;

    // {alu_op, src_a, src_b, result_src, imm_src, adr_src, ir_w, pc_upd, reg_w, mem_w, done, illegal}
    function automatic logic [16:0] ev(input logic [1:0] aop, input logic [1:0] sa,
                                       input logic [1:0] sb, input logic [1:0] rs,
                                       input logic [1:0] imm, input logic adr,
                                       input logic irw, input logic pcu, input logic rw,
                                       input logic mw, input logic dn, input logic il);
        return {aop, sa, sb, rs, imm, adr, irw, pcu, rw, mw, dn, il};
    endfunction

    function automatic logic [16:0] f_fetch(input logic [1:0] imm, input logic rdy);
        return ev(2'b00, 2'b00, 2'b10, 2'b10, imm, 1'b0, rdy, rdy, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic logic [16:0] f_decode(input logic [1:0] imm, input logic il);
        return ev(2'b00, 2'b01, 2'b01, 2'b00, imm, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, il);
    endfunction
    function automatic logic [16:0] f_memadr(input logic [1:0] imm);
        return ev(2'b00, 2'b10, 2'b01, 2'b00, imm, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic logic [16:0] f_memread(input logic [1:0] imm);
        return ev(2'b00, 2'b00, 2'b00, 2'b00, imm, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic logic [16:0] f_memwb(input logic [1:0] imm);
        return ev(2'b00, 2'b00, 2'b00, 2'b01, imm, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    endfunction
    function automatic logic [16:0] f_memwrite(input logic [1:0] imm, input logic mw, input logic dn);
        return ev(2'b00, 2'b00, 2'b00, 2'b00, imm, 1'b1, 1'b0, 1'b0, 1'b0, mw, dn, 1'b0);
    endfunction
    function automatic logic [16:0] f_execr(input logic [1:0] imm);
        return ev(2'b10, 2'b10, 2'b00, 2'b00, imm, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic logic [16:0] f_execi(input logic [1:0] imm);
        return ev(2'b10, 2'b10, 2'b01, 2'b00, imm, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic logic [16:0] f_aluwb(input logic [1:0] imm);
        return ev(2'b00, 2'b00, 2'b00, 2'b00, imm, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    endfunction
    function automatic logic [16:0] f_jal(input logic [1:0] imm);
        return ev(2'b00, 2'b01, 2'b10, 2'b00, imm, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic logic [16:0] f_branch(input logic [1:0] imm, input logic tk);
        return ev(2'b01, 2'b10, 2'b00, 2'b00, imm, 1'b0, 1'b0, tk, 1'b0, 1'b0, 1'b1, 1'b0);
    endfunction

    // One clock cycle: drive reset/mem_ready, queue the expectation, check mid-cycle.
    task automatic cyc(input logic rst, input logic rdy, input logic [16:0] e, input string tag);
        sb_t         ent;
        sb_t         got;
        logic [16:0] obs;
        reset         = rst;
        bus.mem_ready = rdy;
        ent.tag  = tag;
        ent.exp  = e;
        ent.mask = mask_v;
        sb_q.push_back(ent);
        @(negedge clk);
        obs = {bus.alu_op, bus.alu_src_a, bus.alu_src_b, bus.result_src, bus.imm_src,
               bus.adr_src, bus.ir_write, bus.pc_update, bus.reg_write, bus.mem_write,
               bus.instr_done, bus.illegal};
        got = sb_q.pop_front();
        checks++;
        assert ((obs & got.mask) === (got.exp & got.mask))
        else begin
            errors++;
            $error("FAIL %s observed=%05h expected=%05h mask=%05h",
                   got.tag, obs, got.exp, got.mask);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset         = 1'b1;
        bus.mem_ready = 1'b1;
        bus.op        = 7'b0110011;
        bus.func3     = 3'b000;
        bus.zero      = 1'b0;
        bus.lt        = 1'b0;
        @(posedge clk);
        #1;

        // Reset: state unknown in the first cycle, so only the strobes are checked.
        mask_v = 17'h0003F;
        cyc(1'b1, 1'b1, 17'h00000, "reset_c1_strobes");
        mask_v = 17'h1FFFF;
        cyc(1'b1, 1'b1, f_fetch(2'b00, 1'b0), "reset_c2_fetch_gated");

        // R-type, zero wait states
        cyc(1'b0, 1'b1, f_fetch(2'b00, 1'b1), "r_fetch");
        cyc(1'b0, 1'b0, f_decode(2'b00, 1'b0), "r_decode");
        cyc(1'b0, 1'b0, f_execr(2'b00), "r_execr");
        cyc(1'b0, 1'b0, f_aluwb(2'b00), "r_aluwb");

        // lw with three wait states in MEMREAD
        bus.op = 7'b0000011;
        cyc(1'b0, 1'b1, f_fetch(2'b00, 1'b1), "lw_fetch");
        cyc(1'b0, 1'b1, f_decode(2'b00, 1'b0), "lw_decode");
        cyc(1'b0, 1'b1, f_memadr(2'b00), "lw_memadr");
        cyc(1'b0, 1'b0, f_memread(2'b00), "lw_memread_w1");
        cyc(1'b0, 1'b0, f_memread(2'b00), "lw_memread_w2");
        cyc(1'b0, 1'b0, f_memread(2'b00), "lw_memread_w3");
        cyc(1'b0, 1'b1, f_memread(2'b00), "lw_memread_rdy");
        cyc(1'b0, 1'b0, f_memwb(2'b00), "lw_memwb");

        // sw with one FETCH wait and two MEMWRITE waits
        bus.op = 7'b0100011;
        cyc(1'b0, 1'b0, f_fetch(2'b01, 1'b0), "sw_fetch_wait");
        cyc(1'b0, 1'b1, f_fetch(2'b01, 1'b1), "sw_fetch");
        cyc(1'b0, 1'b0, f_decode(2'b01, 1'b0), "sw_decode");
        cyc(1'b0, 1'b0, f_memadr(2'b01), "sw_memadr");
        cyc(1'b0, 1'b0, f_memwrite(2'b01, 1'b1, 1'b0), "sw_memwrite_w1");
        cyc(1'b0, 1'b0, f_memwrite(2'b01, 1'b1, 1'b0), "sw_memwrite_w2");
        cyc(1'b0, 1'b1, f_memwrite(2'b01, 1'b1, 1'b1), "sw_memwrite_done");

        // Branches: beq taken, bne not taken, blt taken, unsupported func3
        bus.op = 7'b1100011;
        bus.func3 = 3'b000; bus.zero = 1'b1; bus.lt = 1'b0;
        cyc(1'b0, 1'b1, f_fetch(2'b10, 1'b1), "beq_fetch");
        cyc(1'b0, 1'b0, f_decode(2'b10, 1'b0), "beq_decode");
        cyc(1'b0, 1'b0, f_branch(2'b10, 1'b1), "beq_taken");
        bus.func3 = 3'b001; bus.zero = 1'b1; bus.lt = 1'b0;
        cyc(1'b0, 1'b1, f_fetch(2'b10, 1'b1), "bne_fetch");
        cyc(1'b0, 1'b0, f_decode(2'b10, 1'b0), "bne_decode");
        cyc(1'b0, 1'b0, f_branch(2'b10, 1'b0), "bne_not_taken");
        bus.func3 = 3'b100; bus.zero = 1'b0; bus.lt = 1'b1;
        cyc(1'b0, 1'b1, f_fetch(2'b10, 1'b1), "blt_fetch");
        cyc(1'b0, 1'b0, f_decode(2'b10, 1'b0), "blt_decode");
        cyc(1'b0, 1'b0, f_branch(2'b10, 1'b1), "blt_taken");
        bus.func3 = 3'b010; bus.zero = 1'b1; bus.lt = 1'b1;
        cyc(1'b0, 1'b1, f_fetch(2'b10, 1'b1), "b010_fetch");
        cyc(1'b0, 1'b0, f_decode(2'b10, 1'b0), "b010_decode");
        cyc(1'b0, 1'b0, f_branch(2'b10, 1'b0), "b010_never");

        // jal
        bus.op = 7'b1101111; bus.func3 = 3'b000; bus.zero = 1'b0; bus.lt = 1'b0;
        cyc(1'b0, 1'b1, f_fetch(2'b11, 1'b1), "jal_fetch");
        cyc(1'b0, 1'b0, f_decode(2'b11, 1'b0), "jal_decode");
        cyc(1'b0, 1'b0, f_jal(2'b11), "jal_jal");
        cyc(1'b0, 1'b0, f_aluwb(2'b11), "jal_aluwb");

        // I-type
        bus.op = 7'b0010011;
        cyc(1'b0, 1'b1, f_fetch(2'b00, 1'b1), "i_fetch");
        cyc(1'b0, 1'b1, f_decode(2'b00, 1'b0), "i_decode");
        cyc(1'b0, 1'b1, f_execi(2'b00), "i_execi");
        cyc(1'b0, 1'b1, f_aluwb(2'b00), "i_aluwb");

        // Unsupported opcode: one illegal pulse, then straight back to FETCH
        bus.op = 7'b1110011;
        cyc(1'b0, 1'b1, f_fetch(2'b00, 1'b1), "ill_fetch");
        cyc(1'b0, 1'b1, f_decode(2'b00, 1'b1), "ill_decode");
        cyc(1'b0, 1'b0, f_fetch(2'b00, 1'b0), "ill_next_fetch");

        // Reset during a MEMWRITE wait aborts the store without a write strobe
        bus.op = 7'b0100011;
        cyc(1'b0, 1'b1, f_fetch(2'b01, 1'b1), "swr_fetch");
        cyc(1'b0, 1'b0, f_decode(2'b01, 1'b0), "swr_decode");
        cyc(1'b0, 1'b0, f_memadr(2'b01), "swr_memadr");
        cyc(1'b0, 1'b0, f_memwrite(2'b01, 1'b1, 1'b0), "swr_memwrite_wait");
        cyc(1'b1, 1'b1, f_memwrite(2'b01, 1'b0, 1'b0), "swr_reset_gated");
        cyc(1'b0, 1'b1, f_fetch(2'b01, 1'b1), "swr_after_reset_fetch");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main FSM for the multi-cycle RV32I core. Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the ALU decoder's alu_op, the datapath mux selects and the register/memory write strobes.
- Sits between the instruction register (op, func3) and the shared single-port instruction/data memory, whose wait states it honours.

Parameters:
- none. State encoding is fixed, 4 bits.

Ports:
- clk  input  1  system clock; everything samples on the rising edge
- reset  input  1  synchronous, active-high reset
- op  input  7  opcode field from the instruction register
- func3  input  3  func3 field from the instruction register
- zero  input  1  ALU result == 0
- lt  input  1  signed rs1 < rs2, from the ALU compare
- mem_ready  input  1  memory has completed the current access this cycle
- alu_op  output  2  to alu_decoder: 00 add, 01 branch compare, 10 R/I decode
- alu_src_a  output  2  00 pc, 01 old_pc, 10 rs1 register
- alu_src_b  output  2  00 rs2 register, 01 immediate, 10 constant 4
- result_src  output  2  00 alu_out register, 01 read data, 10 ALU result (direct)
- imm_src  output  2  00 I, 01 S, 10 B, 11 J
- adr_src  output  1  memory address: 0 pc, 1 result
- ir_write  output  1  load the instruction register
- pc_update  output  1  load pc from result
- reg_write  output  1  register file write enable
- mem_write  output  1  memory write request
- instr_done  output  1  one-cycle pulse on an instruction's final cycle
- illegal  output  1  one-cycle pulse on an unsupported opcode

Behaviour:
- Moore FSM with a registered state. Outputs are combinational from state, plus the gating terms listed below.
- Any output not listed for a state is 0.
- imm_src is combinational from op in every state:
  - 0000011 (lw) or 0010011 (I-type): 00
  - 0100011 (sw): 01
  - 1100011 (branch): 10
  - 1101111 (jal): 11
  - anything else: 00
- Reset:
  - While reset is high, state <= FETCH on the edge.
  - During the reset cycle, ir_write, pc_update, reg_write, mem_write, instr_done and illegal are all forced to 0.
  - Reset asserted in any state, including a memory wait, aborts the instruction. No write strobe is issued in that cycle.
- FETCH:
  - Outputs: adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - ir_write = pc_update = mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when it is 1.
- DECODE:
  - Outputs: alu_src_a=01, alu_src_b=01, alu_op=00 (branch/jump target into alu_out).
  - Next state by op: lw/sw -> MEMADR, R-type 0110011 -> EXECR, I-type -> EXECI, branch -> BRANCH, jal -> JAL.
  - Any other op -> FETCH, with illegal=1 for this cycle. pc has already advanced by 4 in FETCH.
- MEMADR:
  - Outputs: alu_src_a=10, alu_src_b=01, alu_op=00.
  - Next state: lw -> MEMREAD, sw -> MEMWRITE.
- MEMREAD:
  - Outputs: adr_src=1, result_src=00.
  - Wait in MEMREAD until mem_ready=1, then go to MEMWB.
- MEMWB:
  - Outputs: result_src=01, reg_write=1, instr_done=1.
  - Next state: FETCH.
- MEMWRITE:
  - Outputs: adr_src=1, result_src=00, mem_write=1 (held high for the whole wait).
  - On mem_ready=1: instr_done=1 and go to FETCH.
- EXECR:
  - Outputs: alu_src_a=10, alu_src_b=00, alu_op=10.
  - Next state: ALUWB.
- EXECI:
  - Outputs: alu_src_a=10, alu_src_b=01, alu_op=10.
  - Next state: ALUWB.
- ALUWB:
  - Outputs: result_src=00, reg_write=1, instr_done=1.
  - Next state: FETCH.
- JAL:
  - Outputs: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update=1.
  - Next state: ALUWB, which writes old_pc+4 to rd.
- BRANCH:
  - Outputs: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, instr_done=1.
  - pc_update = taken, where taken is:
    - func3 000: zero
    - func3 001: !zero
    - func3 100: lt
    - any other func3: 0
  - Next state: FETCH.
- Instruction latencies with zero wait states:
  - lw: 5 cycles
  - sw: 4 cycles
  - R, I and jal: 4 cycles
  - branch: 3 cycles
- Each mem_ready=0 cycle in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- Unreachable state encodings go to FETCH on the next edge, with all strobes 0.
- mem_ready is ignored outside FETCH, MEMREAD and MEMWRITE.

Test Plan:
- Reset held 2 cycles, then released with mem_ready=1 and op=0110011 -> FETCH (ir_write=1, pc_update=1), DECODE, EXECR (alu_op=10), ALUWB (reg_write=1, instr_done=1). The next cycle is FETCH again; total 4 cycles.
- lw (op=0000011) with mem_ready=0 for 3 cycles in MEMREAD -> MEMREAD held for 4 cycles with adr_src=1. Then MEMWB with result_src=01, reg_write=1; lw total 8 cycles.
- sw (op=0100011), mem_ready low for 1 cycle in FETCH and 2 cycles in MEMWRITE -> mem_write=1 for 3 consecutive cycles, instr_done on the 3rd; sw total 7 cycles.
- Branches, each a separate instruction:
  - func3=000, zero=1 -> pc_update=1.
  - func3=001, zero=1 -> pc_update=0.
  - func3=100, lt=1 -> pc_update=1.
  - func3=010 -> pc_update=0.
  - In all four cases alu_op=01 and instr_done=1 in BRANCH.
- jal (op=1101111) -> imm_src=11; the JAL state shows pc_update=1 with alu_src_a=01, alu_src_b=10; ALUWB then shows reg_write=1.
- op=1110011 -> illegal=1 for exactly one cycle in DECODE, FETCH follows, and reg_write and mem_write never assert.
- Reset asserted mid-instruction in MEMWRITE -> mem_write=0 in that cycle and state is FETCH on the next cycle.
